// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO between the UART receiver and transmitter in the echo path.
// Flags are registered from the next-state occupancy, so they track Count exactly.
module uart_byte_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WrEn,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdEn,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              Full,
    output logic              Empty,
    output logic              AlmostFull,
    output logic              AlmostEmpty,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    output logic              Underflow,
    input  logic              ErrClr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic              wrAcc;
    logic              rdAcc;
    logic [CNT_W-1:0]  countNext;

    // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
    always_comb begin
        rdAcc     = RdEn & ~Empty;
        wrAcc     = WrEn & (~Full | rdAcc);
        countNext = Count;
        if (wrAcc && !rdAcc) begin
            countNext = Count + CNT_W'(1);
        end else if (rdAcc && !wrAcc) begin
            countNext = Count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (wrAcc) begin
            mem[wrPtr] <= WrData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            Count       <= '0;
            RdData      <= '0;
            RdValid     <= 1'b0;
            Full        <= 1'b0;
            Empty       <= 1'b1;
            AlmostFull  <= 1'b0;
            AlmostEmpty <= 1'b1;
        end else begin
            RdValid <= rdAcc;
            if (wrAcc) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (rdAcc) begin
                rdPtr  <= rdPtr + ADDR_W'(1);
                RdData <= mem[rdPtr];
            end
            Count       <= countNext;
            Full        <= (countNext == CNT_W'(DEPTH));
            Empty       <= (countNext == '0);
            AlmostFull  <= (countNext >= CNT_W'(AF_LEVEL));
            AlmostEmpty <= (countNext <= CNT_W'(AE_LEVEL));
        end
    end

    // Sticky error flags; a clear wins over a new error in the same cycle.
    always_ff @(posedge Clk) begin
        if (Rst || ErrClr) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (WrEn && !wrAcc) begin
                Overflow <= 1'b1;
            end
            if (RdEn && !rdAcc) begin
                Underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_byte_fifo.md
# uart_byte_fifo

Parametrised synchronous FIFO that buffers received UART characters between the receiver and the transmitter in the loopback/echo path. Single-cycle write and read strobes are generated in the Clk domain from the receiver's and transmitter's done pulses. The FIFO provides:
- full, empty, almost-full and almost-empty flags;
- an occupancy count;
- sticky overflow and underflow error flags.

Data is never overwritten when full and never re-read when empty.

## Interface
Parameters:
- DATA_W, 8: width of one stored word (UART character).
- ADDR_W, 4: log2 of depth; DEPTH = 2**ADDR_W entries (default 16).
- AF_LEVEL, 14: AlmostFull asserted when Count >= AF_LEVEL.
- AE_LEVEL, 2: AlmostEmpty asserted when Count <= AE_LEVEL.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- WrEn  in  1  write strobe; one word per cycle while high.
- WrData  in  DATA_W  word to store, sampled with WrEn.
- RdEn  in  1  read strobe; one word per cycle while high.
- RdData  out  DATA_W  word read; registered, valid when RdValid=1, held otherwise.
- RdValid  out  1  one-cycle pulse: RdData updated this cycle.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- AlmostFull  out  1  Count >= AF_LEVEL.
- AlmostEmpty  out  1  Count <= AE_LEVEL.
- Count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- Overflow  out  1  sticky: a write was dropped.
- Underflow  out  1  sticky: a read hit an empty FIFO.
- ErrClr  in  1  clears Overflow and Underflow.

## Operation
- Storage: DEPTH x DATA_W register array. The array is not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0.
- Count: a separate ADDR_W+1-bit register. All flags are derived from the registered Count.

Accept rules, evaluated on pre-edge state:
- wr_acc = WrEn & (!Full | rd_acc).
- rd_acc = RdEn & !Empty.

Per-cycle behaviour:
- On wr_acc: mem[wr_ptr] <= WrData; wr_ptr += 1.
- On rd_acc: RdData <= mem[rd_ptr]; rd_ptr += 1; RdValid <= 1. Otherwise RdValid <= 0 and RdData holds.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither.

Boundary and error conditions:
- Full and simultaneous read+write: both are accepted and Count stays at DEPTH.
- Empty and simultaneous read+write: the write is accepted, the read is rejected (no bypass). Underflow sets and Count becomes 1.
- Overflow <= 1 when WrEn & !wr_acc.
- Underflow <= 1 when RdEn & !rd_acc.
- ErrClr has priority over a new set in the same cycle.
- Rejected operations never move pointers, Count or RdData.

Reset (Rst=1 at a clock edge):
- wr_ptr=0, rd_ptr=0, Count=0.
- RdData=0, RdValid=0.
- Overflow=0, Underflow=0.
- Resulting flags: Empty=1, Full=0, AlmostEmpty=1, AlmostFull=0.
- Reset overrides WrEn, RdEn and ErrClr in the same cycle. Contents written before reset are unreachable afterwards.

## Timing
Read path:
- Read latency is 1 cycle: RdEn accepted at edge N gives RdData and RdValid=1 after edge N.
- Back-to-back reads yield one word per cycle.

Flag and count update:
- Flags and Count reflect state after edge N, visible in cycle N+1.
- A write at edge N clears Empty in cycle N+1. That word is readable by RdEn sampled at edge N+1, giving data after N+1.

Throughput:
- Sustained simultaneous WrEn and RdEn at any non-empty occupancy gives full throughput with constant Count.

Static checks:
- AF_LEVEL must be ≤ DEPTH and AE_LEVEL < DEPTH.
- Enforce both in the testbench. The RTL is not required to check them.

## Test plan
Default parameters: DATA_W=8, ADDR_W=4, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.

1. **Reset state.** Assert Rst for 2 cycles with WrEn=RdEn=1 -> Count=0, Empty=1, AlmostEmpty=1, Full=0, RdValid=0, RdData=0x00, both error flags 0.
2. **Fill, overflow, drain.**
   - Write 0x41..0x50 (16 words): Count reaches 16, Full=1, AlmostFull=1 from Count=14.
   - 17th write of 0xFF: dropped, Overflow=1, Count stays 16.
   - 16 reads: return 0x41..0x50 in order, each RdValid one cycle after RdEn.
   - Result: Empty=1, 0xFF never appears.
3. **Underflow and clear.**
   - RdEn while empty -> RdValid=0, RdData unchanged, Underflow=1.
   - ErrClr pulse -> Underflow=0.
   - ErrClr asserted together with a new underflow -> Underflow stays 0.
4. **Simultaneous read and write.**
   - At Count=16: write 0x5A with a read -> read returns the oldest word, Count=16, Overflow stays 0.
   - At Count=0: write 0x33 with a read -> Count=1, Underflow=1, the next read returns 0x33.
5. **Pointer wrap.** Stream 40 words 0x00..0x27 with reads lagging 3 cycles behind writes -> all 40 words returned in order across 2+ pointer wraps, Count never exceeds 4.
6. **Reset mid-operation.** With Count=7, assert Rst for 1 cycle while WrEn=1 -> Count=0, Empty=1. Then write 0xAB and read -> 0xAB, with no stale data returned.
